halt_detector: RTL and testbench

Watches the core's retirement stream and produces the single-cycle-registered, sticky `isHalt` that the simulation cycle counter consumes to print its count and end the run. It recognises the halt instruction (or an optional retired-instruction limit), lets outstanding stores drain, then raises `isHalt`. It sits between the core's writeback stage and the cycle counter, and exports the halting PC, the cause and the retired-instruction count for end-of-run reporting.

---
 rtl/halt_detector_if.sv | 12 +
 rtl/halt_detector.sv | 63 ++++++
 tb/tb_halt_detector.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/halt_detector_if.sv
// halt_detector_if: retirement stream and store-drain status seen by the halt detector
interface halt_detector_if #(
   parameter int INSTR_W = 16,
   parameter int PC_W    = 16
);
   logic               retire_valid;
   logic [INSTR_W-1:0] retire_instr;
   logic [PC_W-1:0]    retire_pc;
   logic               store_pending;
   modport master (output retire_valid, retire_instr, retire_pc, store_pending);
   modport slave  (input  retire_valid, retire_instr, retire_pc, store_pending);
endinterface

// File: rtl/halt_detector.sv
// halt_detector: detects halt instruction or retire limit, drains stores, then raises sticky isHalt
module halt_detector #(
   parameter int                 INSTR_W      = 16,
   parameter int                 PC_W         = 16,
   parameter logic [INSTR_W-1:0] HALT_INSTR   = 16'hFFFF,
   parameter int unsigned        DRAIN_CYCLES = 4,
   parameter logic [31:0]        MAX_RETIRE   = 32'd0
) (
   input  logic             clk,
   input  logic             rst_n,
   halt_detector_if.slave   rif,
   output logic             isHalt,
   output logic             halt_pending,
   output logic             halt_cause,
   output logic [PC_W-1:0]  halt_pc,
   output logic [31:0]      retired_count
);
   typedef enum logic [1:0] {RUN = 2'b00, DRAIN = 2'b01, HALT = 2'b10} state_t;
   state_t          state_q, state_d;
   logic [7:0]      drain_q, drain_d;
   logic [31:0]     retired_count_q, retired_count_d;
   logic [PC_W-1:0] halt_pc_q, halt_pc_d;
   logic            halt_cause_q, halt_cause_d;
   logic [31:0]     cnt_inc;
   logic            hit_halt, hit_lim, enter;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= RUN;
         drain_q         <= '0;
         retired_count_q <= '0;
         halt_pc_q       <= '0;
         halt_cause_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         drain_q         <= drain_d;
         retired_count_q <= retired_count_d;
         halt_pc_q       <= halt_pc_d;
         halt_cause_q    <= halt_cause_d;
      end
   end
   always_comb begin
      cnt_inc  = (retired_count_q == '1) ? retired_count_q : retired_count_q + 32'd1;
      hit_halt = rif.retire_valid && (rif.retire_instr == HALT_INSTR);
      hit_lim  = rif.retire_valid && (MAX_RETIRE != 32'd0) && (cnt_inc == MAX_RETIRE);
      enter    = (state_q == RUN) && (hit_halt || hit_lim);
      state_d  = enter ? DRAIN :
                 (state_q == DRAIN && !rif.store_pending && drain_q == 8'd0) ? HALT : state_q;
   end
   always_comb begin
      retired_count_d = (state_q == RUN && rif.retire_valid) ? cnt_inc : retired_count_q;
      halt_pc_d       = enter ? rif.retire_pc : halt_pc_q;
      halt_cause_d    = enter ? !hit_halt : halt_cause_q;
      drain_d         = enter ? 8'(DRAIN_CYCLES) :
                        (state_q == DRAIN && !rif.store_pending && drain_q != 8'd0) ? drain_q - 8'd1 : drain_q;
   end
   always_comb begin
      isHalt        = state_q[1];
      halt_pending  = state_q[0];
      halt_cause    = halt_cause_q;
      halt_pc       = halt_pc_q;
      retired_count = retired_count_q;
   end
endmodule

// File: tb/tb_halt_detector.sv
// tb_halt_detector: directed checks of three halt_detector configurations
module tb_halt_detector;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [2:0]       rv = '0, sp = '0;
   logic [2:0][15:0] ins = '0, pcs = '0;
   logic [2:0]       ih, hp, hc;
   logic [2:0][15:0] hpc;
   logic [2:0][31:0] cnt;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   halt_detector_if ia ();
   halt_detector_if ib ();
   halt_detector_if ic ();
   assign ia.retire_valid = rv[0];
   assign ia.retire_instr = ins[0];
   assign ia.retire_pc = pcs[0];
   assign ia.store_pending = sp[0];
   assign ib.retire_valid = rv[1];
   assign ib.retire_instr = ins[1];
   assign ib.retire_pc = pcs[1];
   assign ib.store_pending = sp[1];
   assign ic.retire_valid = rv[2];
   assign ic.retire_instr = ins[2];
   assign ic.retire_pc = pcs[2];
   assign ic.store_pending = sp[2];
   halt_detector #(.DRAIN_CYCLES(4), .MAX_RETIRE(32'd0)) u_a (
      .clk(clk), .rst_n(rst_n), .rif(ia), .isHalt(ih[0]), .halt_pending(hp[0]),
      .halt_cause(hc[0]), .halt_pc(hpc[0]), .retired_count(cnt[0]));
   halt_detector #(.DRAIN_CYCLES(4), .MAX_RETIRE(32'd5)) u_b (
      .clk(clk), .rst_n(rst_n), .rif(ib), .isHalt(ih[1]), .halt_pending(hp[1]),
      .halt_cause(hc[1]), .halt_pc(hpc[1]), .retired_count(cnt[1]));
   halt_detector #(.DRAIN_CYCLES(0), .MAX_RETIRE(32'd0)) u_c (
      .clk(clk), .rst_n(rst_n), .rif(ic), .isHalt(ih[2]), .halt_pending(hp[2]),
      .halt_cause(hc[2]), .halt_pc(hpc[2]), .retired_count(cnt[2]));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step(input int i, input logic v, input logic [15:0] in, input logic [15:0] pc, input logic s);
      rv[i] = v;
      ins[i] = in;
      pcs[i] = pc;
      sp[i] = s;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rv = '0;
      sp = '0;
      ins = '0;
      pcs = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic chk_zero(input int i, input string tag);
      chk({tag, "_isHalt"}, 32'(ih[i]), 32'd0);
      chk({tag, "_pending"}, 32'(hp[i]), 32'd0);
      chk({tag, "_cause"}, 32'(hc[i]), 32'd0);
      chk({tag, "_pc"}, 32'(hpc[i]), 32'd0);
      chk({tag, "_count"}, cnt[i], 32'd0);
   endtask
   initial begin
      do_reset();
      chk_zero(0, "rst");
      for (int j = 0; j < 10; j++) step(0, 1'b1, 16'h1000 + 16'(j), 16'(2 * j), 1'b0);
      chk("t1_pre_pending", 32'(hp[0]), 32'd0);
      step(0, 1'b1, 16'hFFFF, 16'h0040, 1'b0);
      chk("t1_pending", 32'(hp[0]), 32'd1);
      chk("t1_count", cnt[0], 32'd11);
      chk("t1_pc", 32'(hpc[0]), 32'h40);
      chk("t1_cause", 32'(hc[0]), 32'd0);
      for (int j = 1; j <= 4; j++) begin
         step(0, 1'b0, 16'h0, 16'h0, 1'b0);
         chk($sformatf("t1_drain%0d_pending", j), 32'(hp[0]), 32'd1);
         chk($sformatf("t1_drain%0d_isHalt", j), 32'(ih[0]), 32'd0);
      end
      step(0, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("t1_isHalt", 32'(ih[0]), 32'd1);
      chk("t1_pending_off", 32'(hp[0]), 32'd0);
      for (int j = 0; j < 3; j++) step(0, 1'b1, 16'hFFFF, 16'h0099, 1'b1);
      chk("t1_sticky", 32'(ih[0]), 32'd1);
      chk("t1_count_hold", cnt[0], 32'd11);
      chk("t1_pc_hold", 32'(hpc[0]), 32'h40);
      do_reset();
      step(0, 1'b1, 16'h0001, 16'h0002, 1'b0);
      step(0, 1'b1, 16'h0002, 16'h0004, 1'b0);
      step(0, 1'b1, 16'hFFFF, 16'h0050, 1'b0);
      for (int j = 1; j <= 3; j++) begin
         step(0, 1'b1, 16'h0003, 16'h0006, 1'b1);
         chk($sformatf("t2_store%0d_pending", j), 32'(hp[0]), 32'd1);
      end
      for (int j = 4; j <= 7; j++) begin
         step(0, 1'b1, 16'h0004, 16'h0008, 1'b0);
         chk($sformatf("t2_edge%0d_isHalt", j), 32'(ih[0]), 32'd0);
      end
      step(0, 1'b1, 16'h0005, 16'h000A, 1'b0);
      chk("t2_isHalt", 32'(ih[0]), 32'd1);
      chk("t2_count", cnt[0], 32'd3);
      chk("t2_pc", 32'(hpc[0]), 32'h50);
      do_reset();
      for (int j = 0; j < 4; j++) step(1, 1'b1, 16'h0100, 16'(4 * j), 1'b0);
      chk("t3_pre_pending", 32'(hp[1]), 32'd0);
      step(1, 1'b1, 16'h0200, 16'h0010, 1'b0);
      chk("t3_pending", 32'(hp[1]), 32'd1);
      chk("t3_cause", 32'(hc[1]), 32'd1);
      chk("t3_pc", 32'(hpc[1]), 32'h10);
      chk("t3_count", cnt[1], 32'd5);
      for (int j = 0; j < 5; j++) step(1, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("t3_isHalt", 32'(ih[1]), 32'd1);
      do_reset();
      for (int j = 0; j < 4; j++) step(1, 1'b1, 16'h0100, 16'(4 * j), 1'b0);
      step(1, 1'b1, 16'hFFFF, 16'h0014, 1'b0);
      chk("t3b_pending", 32'(hp[1]), 32'd1);
      chk("t3b_cause", 32'(hc[1]), 32'd0);
      chk("t3b_pc", 32'(hpc[1]), 32'h14);
      chk("t3b_count", cnt[1], 32'd5);
      do_reset();
      step(2, 1'b0, 16'h0, 16'h0, 1'b0);
      step(2, 1'b1, 16'hFFFF, 16'h0022, 1'b0);
      chk("t4_pending", 32'(hp[2]), 32'd1);
      chk("t4_isHalt_early", 32'(ih[2]), 32'd0);
      step(2, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("t4_isHalt", 32'(ih[2]), 32'd1);
      chk("t4_count", cnt[2], 32'd1);
      do_reset();
      step(0, 1'b1, 16'hFFFF, 16'h0030, 1'b0);
      step(0, 1'b0, 16'h0, 16'h0, 1'b0);
      step(0, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("t5_mid_pc", 32'(hpc[0]), 32'h30);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero(0, "t5_async");
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1'b1, 16'hFFFF, 16'h0060, 1'b0);
      chk("t5_pending", 32'(hp[0]), 32'd1);
      chk("t5_pc", 32'(hpc[0]), 32'h60);
      chk("t5_count", cnt[0], 32'd1);
      for (int j = 0; j < 4; j++) step(0, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("t5_isHalt_early", 32'(ih[0]), 32'd0);
      step(0, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("t5_isHalt", 32'(ih[0]), 32'd1);
      do_reset();
      @(negedge clk);
      force u_a.retired_count_q = 32'hFFFF_FFFE;
      step(0, 1'b0, 16'h0, 16'h0, 1'b0);
      release u_a.retired_count_q;
      #1;
      chk("t6_forced", cnt[0], 32'hFFFF_FFFE);
      step(0, 1'b1, 16'h0007, 16'h0070, 1'b0);
      chk("t6_first", cnt[0], 32'hFFFF_FFFF);
      step(0, 1'b1, 16'h0007, 16'h0072, 1'b0);
      step(0, 1'b1, 16'h0007, 16'h0074, 1'b0);
      chk("t6_sat", cnt[0], 32'hFFFF_FFFF);
      chk("t6_pending", 32'(hp[0]), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
